// File: rtl/alu_cmd_issuer.sv
// Command front end for the 4-bit ALU: tagged request FIFO, issue/capture FSM, response channel.
// Optional build macro ALU_CMD_ACC_EN adds cmd_acc and an accumulator feeding alu_b.
module alu_cmd_issuer #(
  parameter int DEPTH = 4,
  parameter int TAG_W = 2,
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [3:0]       cmd_a,
  input  logic [3:0]       cmd_b,
  input  logic [2:0]       cmd_op,
  input  logic [TAG_W-1:0] cmd_tag,
`ifdef ALU_CMD_ACC_EN
  input  logic             cmd_acc,
`endif
  output logic [3:0]       alu_a,
  output logic [3:0]       alu_b,
  output logic [2:0]       alu_op,
  input  logic [3:0]       alu_result,
  input  logic             alu_carry,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [3:0]       rsp_result,
  output logic             rsp_carry,
  output logic [TAG_W-1:0] rsp_tag,
  output logic             busy,
  output logic [CNT_W-1:0] fifo_count,
  output logic [1:0]       state_dbg
);

  // Both channels use valid/ready: a transfer happens on the rising edge where valid && ready;
  // the source holds its payload stable while valid is high and ready is low.

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ISSUE   = 2'd1,
    ST_CAPTURE = 2'd2,
    ST_WAIT    = 2'd3
  } state_t;

  state_t state;

  logic [3:0]       mem_a   [DEPTH];
  logic [3:0]       mem_b   [DEPTH];
  logic [2:0]       mem_op  [DEPTH];
  logic [TAG_W-1:0] mem_tag [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             push;
  logic             pop;
  logic [3:0]       head_b;

  assign cmd_ready = (fifo_count != CNT_W'(DEPTH));
  assign push      = cmd_valid && cmd_ready;
  // The head entry leaves the FIFO on the edge that captures its result.
  assign pop       = (state == ST_ISSUE);
  assign busy      = (state != ST_IDLE) || (fifo_count != '0);
  assign state_dbg = state;

`ifdef ALU_CMD_ACC_EN
  logic       mem_acc [DEPTH];
  logic [3:0] acc_q;

  always_ff @(posedge clk) begin
    if (push) begin
      mem_acc[wr_ptr] <= cmd_acc;
    end
  end

  assign head_b = mem_acc[rd_ptr] ? acc_q : mem_b[rd_ptr];
`else
  assign head_b = mem_b[rd_ptr];
`endif

  // Storage needs no reset: only entries below fifo_count are ever read.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_a[wr_ptr]   <= cmd_a;
      mem_b[wr_ptr]   <= cmd_b;
      mem_op[wr_ptr]  <= cmd_op;
      mem_tag[wr_ptr] <= cmd_tag;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      if (push && !pop) begin
        fifo_count <= fifo_count + CNT_W'(1);
      end else if (!push && pop) begin
        fifo_count <= fifo_count - CNT_W'(1);
      end
    end
  end

  // ISSUE is the cycle the ALU inputs are stable; CAPTURE is the first cycle the response
  // is offered, and it completes there if rsp_ready is already high (3-cycle throughput).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      alu_a      <= '0;
      alu_b      <= '0;
      alu_op     <= '0;
      rsp_valid  <= 1'b0;
      rsp_result <= '0;
      rsp_carry  <= 1'b0;
      rsp_tag    <= '0;
`ifdef ALU_CMD_ACC_EN
      acc_q      <= '0;
`endif
    end else begin
      case (state)
        ST_IDLE: begin
          if (fifo_count != '0) begin
            alu_a  <= mem_a[rd_ptr];
            alu_b  <= head_b;
            alu_op <= mem_op[rd_ptr];
            state  <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          rsp_result <= alu_result;
          rsp_carry  <= alu_carry;
          rsp_tag    <= mem_tag[rd_ptr];
          rsp_valid  <= 1'b1;
`ifdef ALU_CMD_ACC_EN
          acc_q      <= alu_result;
`endif
          state      <= ST_CAPTURE;
        end
        ST_CAPTURE, ST_WAIT: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            state     <= ST_IDLE;
          end else begin
            state <= ST_WAIT;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_cmd_issuer.sv
// Directed testbench for alu_cmd_issuer with a behavioural 4-bit ALU attached to alu_*.
module tb_alu_cmd_issuer;

  logic       clk;
  logic       rst_n;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [3:0] cmd_a;
  logic [3:0] cmd_b;
  logic [2:0] cmd_op;
  logic [1:0] cmd_tag;
  logic       cmd_acc;
  logic [3:0] alu_a;
  logic [3:0] alu_b;
  logic [2:0] alu_op;
  logic [3:0] alu_result;
  logic       alu_carry;
  logic       rsp_valid;
  logic       rsp_ready;
  logic [3:0] rsp_result;
  logic       rsp_carry;
  logic [1:0] rsp_tag;
  logic       busy;
  logic [2:0] fifo_count;
  logic [1:0] state_dbg;

  int checks;
  int failures;

  alu_cmd_issuer #(.DEPTH(4), .TAG_W(2)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_a      (cmd_a),
    .cmd_b      (cmd_b),
    .cmd_op     (cmd_op),
    .cmd_tag    (cmd_tag),
`ifdef ALU_CMD_ACC_EN
    .cmd_acc    (cmd_acc),
`endif
    .alu_a      (alu_a),
    .alu_b      (alu_b),
    .alu_op     (alu_op),
    .alu_result (alu_result),
    .alu_carry  (alu_carry),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_result (rsp_result),
    .rsp_carry  (rsp_carry),
    .rsp_tag    (rsp_tag),
    .busy       (busy),
    .fifo_count (fifo_count),
    .state_dbg  (state_dbg)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // behavioural ALU: ADD, SUB(borrow), AND, OR, XOR, NOT a, SHL, SHR
  always_comb begin
    logic [4:0] wide;
    wide = '0;
    case (alu_op)
      3'b000: wide = {1'b0, alu_a} + {1'b0, alu_b};
      3'b001: wide = {1'b0, alu_a} - {1'b0, alu_b};
      3'b010: wide = {1'b0, alu_a & alu_b};
      3'b011: wide = {1'b0, alu_a | alu_b};
      3'b100: wide = {1'b0, alu_a ^ alu_b};
      3'b101: wide = {1'b0, ~alu_a};
      3'b110: wide = {1'b0, alu_a << 1};
      default: wide = {1'b0, alu_a >> 1};
    endcase
    alu_result = wide[3:0];
    alu_carry  = wide[4];
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // driver: present one command for exactly one edge (caller ensures cmd_ready)
  task automatic push(input logic [3:0] a, input logic [3:0] b, input logic [2:0] op,
                      input logic [1:0] tag, input logic acc);
    cmd_valid = 1'b1;
    cmd_a     = a;
    cmd_b     = b;
    cmd_op    = op;
    cmd_tag   = tag;
    cmd_acc   = acc;
    step();
    cmd_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    cmd_valid = 1'b0; cmd_a = '0; cmd_b = '0; cmd_op = '0; cmd_tag = '0; cmd_acc = 1'b0;
    rsp_ready = 1'b1;
    repeat (3) step();
    checks++;
    if (rsp_valid !== 1'b0 || fifo_count !== 3'd0 || busy !== 1'b0) begin
      failures++;
      $display("FAIL reset_status: rsp_valid=%b fifo_count=%0d busy=%b, required 0/0/0",
               rsp_valid, fifo_count, busy);
    end
    checks++;
    if (alu_a !== 4'h0 || alu_b !== 4'h0 || alu_op !== 3'h0 || rsp_result !== 4'h0 ||
        rsp_tag !== 2'd0 || rsp_carry !== 1'b0) begin
      failures++;
      $display("FAIL reset_data: alu=%h/%h/%h rsp=%h/%b/%h, required all 0",
               alu_a, alu_b, alu_op, rsp_result, rsp_carry, rsp_tag);
    end
    @(negedge clk);
    rst_n = 1'b1;
    step();
    checks++;
    if (cmd_ready !== 1'b1 || state_dbg !== 2'd0) begin
      failures++;
      $display("FAIL reset_release: cmd_ready=%b state=%0d, required 1/0", cmd_ready, state_dbg);
    end
  endtask

  task automatic test_add_latency();
    push(4'h9, 4'h8, 3'b000, 2'd1, 1'b0);
    checks++;
    if (fifo_count !== 3'd1 || busy !== 1'b1 || rsp_valid !== 1'b0) begin
      failures++;
      $display("FAIL add_e0: fifo_count=%0d busy=%b rsp_valid=%b, required 1/1/0",
               fifo_count, busy, rsp_valid);
    end
    step();
    checks++;
    if (alu_a !== 4'h9 || alu_b !== 4'h8 || alu_op !== 3'b000 || rsp_valid !== 1'b0 ||
        state_dbg !== 2'd1) begin
      failures++;
      $display("FAIL add_e1: alu=%h/%h/%h rsp_valid=%b state=%0d, required 9/8/0/0/1",
               alu_a, alu_b, alu_op, rsp_valid, state_dbg);
    end
    step();
    checks++;
    if (rsp_valid !== 1'b1 || rsp_result !== 4'h1 || rsp_carry !== 1'b1 || rsp_tag !== 2'd1 ||
        fifo_count !== 3'd0) begin
      failures++;
      $display("FAIL add_e2: valid=%b result=%h carry=%b tag=%0d count=%0d, required 1/1/1/1/0",
               rsp_valid, rsp_result, rsp_carry, rsp_tag, fifo_count);
    end
    step();
    checks++;
    if (rsp_valid !== 1'b0 || busy !== 1'b0 || alu_a !== 4'h9 || alu_b !== 4'h8) begin
      failures++;
      $display("FAIL add_done: valid=%b busy=%b alu=%h/%h, required 0/0/9/8",
               rsp_valid, busy, alu_a, alu_b);
    end
  endtask

  task automatic test_alu_ops();
    logic [3:0] va [3];
    logic [3:0] vb [3];
    logic [2:0] vop [3];
    logic [3:0] vres [3];
    logic       vcar [3];
    va[0] = 4'h3; vb[0] = 4'h5; vop[0] = 3'b001; vres[0] = 4'hE; vcar[0] = 1'b1;
    va[1] = 4'hC; vb[1] = 4'hA; vop[1] = 3'b010; vres[1] = 4'h8; vcar[1] = 1'b0;
    va[2] = 4'hF; vb[2] = 4'h1; vop[2] = 3'b000; vres[2] = 4'h0; vcar[2] = 1'b1;
    for (int i = 0; i < 3; i++) begin
      push(va[i], vb[i], vop[i], 2'(i + 2), 1'b0);
      repeat (2) step();
      checks++;
      if (rsp_valid !== 1'b1 || rsp_result !== vres[i] || rsp_carry !== vcar[i] ||
          rsp_tag !== 2'(i + 2)) begin
        failures++;
        $display("FAIL alu_op_%0d: valid=%b result=%h carry=%b tag=%0d, required 1/%h/%b/%0d",
                 i, rsp_valid, rsp_result, rsp_carry, rsp_tag, vres[i], vcar[i], 2'(i + 2));
      end
      step();
    end
  endtask

  task automatic test_backpressure();
    int waited;
    rsp_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (cmd_ready !== 1'b1) begin
        failures++;
        $display("FAIL bp_ready_%0d: cmd_ready=%b, required 1", i, cmd_ready);
      end
      push(4'(i), 4'h1, 3'b000, 2'(i), 1'b0);
    end
    checks++;
    if (fifo_count !== 3'd4 || cmd_ready !== 1'b0) begin
      failures++;
      $display("FAIL bp_full: fifo_count=%0d cmd_ready=%b, required 4/0", fifo_count, cmd_ready);
    end
    // offer a sixth command while full; it must be refused and the response must not move
    cmd_valid = 1'b1; cmd_a = 4'h7; cmd_b = 4'h7; cmd_op = 3'b000; cmd_tag = 2'd3;
    for (int i = 0; i < 3; i++) begin
      step();
      checks++;
      if (fifo_count !== 3'd4 || rsp_valid !== 1'b1 || rsp_result !== 4'h1 || rsp_tag !== 2'd0) begin
        failures++;
        $display("FAIL bp_hold_%0d: count=%0d valid=%b result=%h tag=%0d, required 4/1/1/0",
                 i, fifo_count, rsp_valid, rsp_result, rsp_tag);
      end
    end
    cmd_valid = 1'b0;
    rsp_ready = 1'b1;
    for (int k = 0; k < 5; k++) begin
      waited = 0;
      while (rsp_valid !== 1'b1 && waited < 10) begin
        step();
        waited++;
      end
      checks++;
      if (rsp_valid !== 1'b1 || rsp_result !== 4'(k + 1) || rsp_tag !== 2'(k) || rsp_carry !== 1'b0) begin
        failures++;
        $display("FAIL bp_rsp_%0d: valid=%b result=%h tag=%0d carry=%b, required 1/%h/%0d/0",
                 k, rsp_valid, rsp_result, rsp_tag, rsp_carry, 4'(k + 1), 2'(k));
      end
      step();
    end
    checks++;
    if (fifo_count !== 3'd0 || busy !== 1'b0 || rsp_valid !== 1'b0) begin
      failures++;
      $display("FAIL bp_drained: count=%0d busy=%b valid=%b, required 0/0/0",
               fifo_count, busy, rsp_valid);
    end
  endtask

  task automatic test_reset_mid();
    rsp_ready = 1'b0;
    push(4'h7, 4'h2, 3'b000, 2'd2, 1'b0);
    push(4'h5, 4'h5, 3'b000, 2'd3, 1'b0);
    step();
    checks++;
    if (state_dbg !== 2'd2 || rsp_valid !== 1'b1 || rsp_result !== 4'h9) begin
      failures++;
      $display("FAIL rst_mid_pre: state=%0d valid=%b result=%h, required 2/1/9",
               state_dbg, rsp_valid, rsp_result);
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if (rsp_valid !== 1'b0 || fifo_count !== 3'd0 || alu_a !== 4'h0 || alu_b !== 4'h0 ||
        rsp_result !== 4'h0 || state_dbg !== 2'd0 || busy !== 1'b0) begin
      failures++;
      $display("FAIL rst_mid: valid=%b count=%0d alu=%h/%h result=%h state=%0d busy=%b, required all 0",
               rsp_valid, fifo_count, alu_a, alu_b, rsp_result, state_dbg, busy);
    end
    @(negedge clk);
    rst_n = 1'b1;
    rsp_ready = 1'b1;
    repeat (3) step();
    checks++;
    if (rsp_valid !== 1'b0 || cmd_ready !== 1'b1 || busy !== 1'b0) begin
      failures++;
      $display("FAIL rst_mid_after: valid=%b ready=%b busy=%b, required 0/1/0",
               rsp_valid, cmd_ready, busy);
    end
  endtask

  task automatic test_back_to_back();
    int sent;
    int got;
    int last_cyc;
    sent = 0;
    got = 0;
    last_cyc = -1;
    rsp_ready = 1'b1;
    for (int cyc = 0; cyc < 60 && got < 6; cyc++) begin
      if (sent < 6) begin
        cmd_valid = 1'b1;
        cmd_a = 4'(sent * 2); cmd_b = 4'h3; cmd_op = 3'b000; cmd_tag = 2'(sent); cmd_acc = 1'b0;
      end else begin
        cmd_valid = 1'b0;
      end
      if (cmd_valid && cmd_ready) sent++;
      step();
      if (rsp_valid === 1'b1) begin
        checks++;
        if (rsp_tag !== 2'(got) || rsp_result !== 4'(got * 2 + 3) || rsp_carry !== 1'b0) begin
          failures++;
          $display("FAIL b2b_rsp_%0d: result=%h tag=%0d carry=%b, required %h/%0d/0",
                   got, rsp_result, rsp_tag, rsp_carry, 4'(got * 2 + 3), 2'(got));
        end
        if (last_cyc >= 0) begin
          checks++;
          if (cyc - last_cyc != 3) begin
            failures++;
            $display("FAIL b2b_gap_%0d: gap=%0d cycles, required 3", got, cyc - last_cyc);
          end
        end
        last_cyc = cyc;
        got++;
      end
    end
    cmd_valid = 1'b0;
    checks++;
    if (got != 6) begin
      failures++;
      $display("FAIL b2b_count: responses=%0d, required 6", got);
    end
    step();
  endtask

`ifdef ALU_CMD_ACC_EN
  task automatic test_acc();
    rsp_ready = 1'b1;
    push(4'h1, 4'h1, 3'b000, 2'd0, 1'b0);
    repeat (2) step();
    checks++;
    if (rsp_valid !== 1'b1 || rsp_result !== 4'h2) begin
      failures++;
      $display("FAIL acc_first: valid=%b result=%h, required 1/2", rsp_valid, rsp_result);
    end
    step();
    push(4'h2, 4'h7, 3'b000, 2'd1, 1'b1);
    step();
    checks++;
    if (alu_b !== 4'h2) begin
      failures++;
      $display("FAIL acc_alu_b: alu_b=%h, required 2", alu_b);
    end
    step();
    checks++;
    if (rsp_valid !== 1'b1 || rsp_result !== 4'h4 || rsp_tag !== 2'd1) begin
      failures++;
      $display("FAIL acc_second: valid=%b result=%h tag=%0d, required 1/4/1",
               rsp_valid, rsp_result, rsp_tag);
    end
    step();
  endtask
`endif

  initial begin
    checks = 0;
    failures = 0;
    test_reset();
    test_add_latency();
    test_alu_ops();
    test_backpressure();
    test_reset_mid();
    test_back_to_back();
`ifdef ALU_CMD_ACC_EN
    test_acc();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
